// File: rtl/rv_pkg.sv
// Shared RV32I pipeline constants: datapath width, ResultSrc encodings and load funct3 codes.
package rv_pkg;

    localparam int XLEN = 32;

    localparam logic [1:0] RES_ALU = 2'b00;
    localparam logic [1:0] RES_MEM = 2'b01;
    localparam logic [1:0] RES_PC4 = 2'b10;
    localparam logic [1:0] RES_RSV = 2'b11;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

endpackage

// File: rtl/load_extend.sv
// Combinational load lane extraction and sign/zero extension, plus misalignment detect.
// Misaligned accesses still return the aligned-lane data; only the flag reports them.
module load_extend
    import rv_pkg::*;
#(
    parameter int XLEN = rv_pkg::XLEN
) (
    input  logic [XLEN-1:0] raw_i,
    input  logic [2:0]      funct3_i,
    input  logic [1:0]      offset_i,
    output logic [XLEN-1:0] data_o,
    output logic            misaligned_o
);

    logic [7:0]  byte_s;
    logic [15:0] half_s;

    // Select the addressed byte and halfword lanes from the raw word
    always_comb begin
        byte_s = 8'h00;
        case (offset_i)
            2'd0:    byte_s = raw_i[7:0];
            2'd1:    byte_s = raw_i[15:8];
            2'd2:    byte_s = raw_i[23:16];
            2'd3:    byte_s = raw_i[31:24];
            default: byte_s = 8'h00;
        endcase
        if (offset_i[1]) begin
            half_s = raw_i[31:16];
        end else begin
            half_s = raw_i[15:0];
        end
    end

    // Extend the selected lane; unknown funct3 codes behave as lw
    always_comb begin
        data_o       = raw_i;
        misaligned_o = 1'b0;
        case (funct3_i)
            F3_LB:  data_o = {{(XLEN-8){byte_s[7]}}, byte_s};
            F3_LBU: data_o = {{(XLEN-8){1'b0}}, byte_s};
            F3_LH: begin
                data_o       = {{(XLEN-16){half_s[15]}}, half_s};
                misaligned_o = offset_i[0];
            end
            F3_LHU: begin
                data_o       = {{(XLEN-16){1'b0}}, half_s};
                misaligned_o = offset_i[0];
            end
            F3_LW: begin
                data_o       = raw_i;
                misaligned_o = (offset_i != 2'd0);
            end
            default: begin
                data_o       = raw_i;
                misaligned_o = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/writeback_stage.sv
// MEM/WB pipeline register with result selection, x0 write suppression,
// retired-instruction counter and sticky misaligned-load flag.
module writeback_stage
    import rv_pkg::*;
#(
    parameter int XLEN  = rv_pkg::XLEN,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             stall,
    input  logic             flush,
    input  logic             m_valid,
    input  logic             m_RegWrite,
    input  logic [1:0]       m_ResultSrc,
    input  logic [2:0]       m_Funct3,
    input  logic [4:0]       m_Rd,
    input  logic [XLEN-1:0]  m_ALUResult,
    input  logic [XLEN-1:0]  m_ReadData,
    input  logic [XLEN-1:0]  m_PCPlus4,
    output logic [XLEN-1:0]  WB,
    output logic [4:0]       Rd_W,
    output logic             RegWrite_W,
    output logic             valid_W,
    output logic [CNT_W-1:0] retire_count,
    output logic             load_misaligned
);

    logic [XLEN-1:0]  load_data_s;
    logic             load_mis_s;
    logic [XLEN-1:0]  result_s;
    logic             regwrite_s;

    logic [XLEN-1:0]  wb_q,  wb_d;
    logic [4:0]       rd_q,  rd_d;
    logic             rw_q,  rw_d;
    logic             vld_q, vld_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             mis_q, mis_d;

    load_extend #(.XLEN(XLEN)) u_load_extend (
        .raw_i        (m_ReadData),
        .funct3_i     (m_Funct3),
        .offset_i     (m_ALUResult[1:0]),
        .data_o       (load_data_s),
        .misaligned_o (load_mis_s)
    );

    // Result mux ahead of the register so WB leaves the stage registered
    always_comb begin
        result_s = {XLEN{1'b0}};
        case (m_ResultSrc)
            RES_ALU: result_s = m_ALUResult;
            RES_MEM: result_s = load_data_s;
            RES_PC4: result_s = m_PCPlus4;
            default: result_s = {XLEN{1'b0}};
        endcase
        regwrite_s = m_valid & m_RegWrite & (m_Rd != 5'd0) & (m_ResultSrc != RES_RSV);
    end

    // Next-state with flush > stall > capture priority
    always_comb begin
        wb_d  = wb_q;
        rd_d  = rd_q;
        rw_d  = rw_q;
        vld_d = vld_q;
        cnt_d = cnt_q;
        mis_d = mis_q;
        if (flush) begin
            vld_d = 1'b0;
            rw_d  = 1'b0;
        end else if (stall) begin
            vld_d = vld_q;
        end else begin
            wb_d  = result_s;
            rd_d  = m_Rd;
            rw_d  = regwrite_s;
            vld_d = m_valid;
            if (m_valid) begin
                cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
            end else begin
                cnt_d = cnt_q;
            end
            mis_d = mis_q | (m_valid & (m_ResultSrc == RES_MEM) & load_mis_s);
        end
    end

    // MEM/WB state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_q  <= {XLEN{1'b0}};
            rd_q  <= 5'd0;
            rw_q  <= 1'b0;
            vld_q <= 1'b0;
            cnt_q <= {CNT_W{1'b0}};
            mis_q <= 1'b0;
        end else begin
            wb_q  <= wb_d;
            rd_q  <= rd_d;
            rw_q  <= rw_d;
            vld_q <= vld_d;
            cnt_q <= cnt_d;
            mis_q <= mis_d;
        end
    end

    assign WB              = wb_q;
    assign Rd_W            = rd_q;
    assign RegWrite_W      = rw_q;
    assign valid_W         = vld_q;
    assign retire_count    = cnt_q;
    assign load_misaligned = mis_q;

endmodule

// File: tb/tb_writeback_stage.sv
// Scoreboard bench for writeback_stage; a second 4-bit-counter instance covers counter wrap.
module tb_writeback_stage;

    typedef struct packed {
        logic [31:0] wb;
        logic [4:0]  rd;
        logic        rw;
        logic        v;
        logic [31:0] cnt;
        logic        mis;
        logic [3:0]  cnt4;
        logic [39:0] b2;
    } obs_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        stall = 1'b0, flush = 1'b0;
    logic        m_valid = 1'b0, m_RegWrite = 1'b0;
    logic [1:0]  m_ResultSrc = 2'b00;
    logic [2:0]  m_Funct3 = 3'b000;
    logic [4:0]  m_Rd = 5'd0;
    logic [31:0] m_ALUResult = 32'h0, m_ReadData = 32'h0, m_PCPlus4 = 32'h0;

    logic [31:0] WB, s2_wb;
    logic [4:0]  Rd_W, s2_rd;
    logic        RegWrite_W, valid_W, load_misaligned, s2_rw, s2_v, s2_mis;
    logic [31:0] retire_count;
    logic [3:0]  s2_cnt;

    obs_t sb[$];
    obs_t mdl;
    obs_t got, exp;
    int   n_checks = 0;
    int   n_pass = 0;

    always #5 clk = ~clk;

    writeback_stage #(.XLEN(32), .CNT_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
        .m_valid(m_valid), .m_RegWrite(m_RegWrite), .m_ResultSrc(m_ResultSrc),
        .m_Funct3(m_Funct3), .m_Rd(m_Rd), .m_ALUResult(m_ALUResult),
        .m_ReadData(m_ReadData), .m_PCPlus4(m_PCPlus4),
        .WB(WB), .Rd_W(Rd_W), .RegWrite_W(RegWrite_W), .valid_W(valid_W),
        .retire_count(retire_count), .load_misaligned(load_misaligned)
    );

    writeback_stage #(.XLEN(32), .CNT_W(4)) dut_small (
        .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
        .m_valid(m_valid), .m_RegWrite(m_RegWrite), .m_ResultSrc(m_ResultSrc),
        .m_Funct3(m_Funct3), .m_Rd(m_Rd), .m_ALUResult(m_ALUResult),
        .m_ReadData(m_ReadData), .m_PCPlus4(m_PCPlus4),
        .WB(s2_wb), .Rd_W(s2_rd), .RegWrite_W(s2_rw), .valid_W(s2_v),
        .retire_count(s2_cnt), .load_misaligned(s2_mis)
    );

    function automatic obs_t observe();
        obs_t o;
        o.wb   = WB;
        o.rd   = Rd_W;
        o.rw   = RegWrite_W;
        o.v    = valid_W;
        o.cnt  = retire_count;
        o.mis  = load_misaligned;
        o.cnt4 = s2_cnt;
        o.b2   = {s2_wb, s2_rd, s2_rw, s2_v, s2_mis};
        return o;
    endfunction

    // Reference load extraction, written with shifts rather than lane muxes
    function automatic logic [31:0] ext_model(input logic [31:0] w, input logic [2:0] f3,
                                              input logic [1:0] off);
        logic [31:0] sb_w, sh_w;
        sb_w = w >> {off, 3'b000};
        sh_w = w >> {off[1], 4'b0000};
        case (f3)
            3'b000:  return {{24{sb_w[7]}}, sb_w[7:0]};
            3'b100:  return {24'h0, sb_w[7:0]};
            3'b001:  return {{16{sh_w[15]}}, sh_w[15:0]};
            3'b101:  return {16'h0, sh_w[15:0]};
            default: return w;
        endcase
    endfunction

    function automatic logic mis_model(input logic [2:0] f3, input logic [1:0] off);
        return ((f3 == 3'b001 || f3 == 3'b101) && off[0]) || (f3 == 3'b010 && off != 2'b00);
    endfunction

    task automatic model_reset();
        mdl = '0;
        sb.delete();
    endtask

    // Drive one MEM-stage slot, push the expected W state, and advance past the edge
    task automatic drive(input logic st, input logic fl, input logic v, input logic rw,
                         input logic [1:0] src, input logic [2:0] f3, input logic [4:0] rd,
                         input logic [31:0] alu, input logic [31:0] rdat, input logic [31:0] pc4);
        @(negedge clk);
        stall = st; flush = fl; m_valid = v; m_RegWrite = rw; m_ResultSrc = src;
        m_Funct3 = f3; m_Rd = rd; m_ALUResult = alu; m_ReadData = rdat; m_PCPlus4 = pc4;
        if (fl) begin
            mdl.v  = 1'b0;
            mdl.rw = 1'b0;
        end else if (!st) begin
            case (src)
                2'b00:   mdl.wb = alu;
                2'b01:   mdl.wb = ext_model(rdat, f3, alu[1:0]);
                2'b10:   mdl.wb = pc4;
                default: mdl.wb = 32'h0;
            endcase
            mdl.rd = rd;
            mdl.rw = v && rw && (rd != 5'd0) && (src != 2'b11);
            mdl.v  = v;
            if (v) mdl.cnt = mdl.cnt + 32'd1;
            if (v && src == 2'b01 && mis_model(f3, alu[1:0])) mdl.mis = 1'b1;
        end
        mdl.cnt4 = mdl.cnt[3:0];
        mdl.b2   = {mdl.wb, mdl.rd, mdl.rw, mdl.v, mdl.mis};
        sb.push_back(mdl);
        @(posedge clk);
        #1;
        stall = 1'b0; flush = 1'b0;
    endtask

    task automatic test_reset();
        model_reset();
        #1 rst_n = 1'b0;
        #1 got = observe();
        n_checks++;
        if (got !== '0) $display("FAIL reset_init got=%h exp=0", got);
        else n_pass++;
        @(negedge clk) rst_n = 1'b1;
    endtask

    task automatic test_alu_write();
        for (int i = 0; i < 2; i++) begin
            case (i)
                0:       drive(0, 0, 1, 1, 2'b00, 3'b000, 5'd5, 32'h0000000A, 32'h0, 32'h0);
                default: drive(0, 0, 1, 1, 2'b00, 3'b000, 5'd31, 32'hDEADBEEF, 32'h0, 32'h0);
            endcase
            exp = sb.pop_front(); got = observe(); n_checks++;
            if (got !== exp) $display("FAIL alu_write[%0d] got=%h exp=%h", i, got, exp);
            else n_pass++;
        end
    endtask

    task automatic test_x0_jal();
        for (int i = 0; i < 3; i++) begin
            case (i)
                0:       drive(0, 0, 1, 1, 2'b00, 3'b000, 5'd0, 32'h12345678, 32'h0, 32'h0);
                1:       drive(0, 0, 1, 1, 2'b10, 3'b000, 5'd1, 32'h00000200, 32'h0, 32'h104);
                default: drive(0, 0, 1, 1, 2'b11, 3'b000, 5'd9, 32'h55555555, 32'h0, 32'h0);
            endcase
            exp = sb.pop_front(); got = observe(); n_checks++;
            if (got !== exp) $display("FAIL x0_jal[%0d] got=%h exp=%h", i, got, exp);
            else n_pass++;
        end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        stall = 1'b1; flush = 1'b1; m_valid = 1'b1;
        got = observe(); n_checks++;
        if (got.cnt !== 32'd5) $display("FAIL pre_reset_count got=%0d exp=5", got.cnt);
        else n_pass++;
        #2 rst_n = 1'b0;
        #1 got = observe(); n_checks++;
        if (got !== '0) $display("FAIL reset_mid got=%h exp=0", got);
        else n_pass++;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1; stall = 1'b0; flush = 1'b0; m_valid = 1'b0;
    endtask

    task automatic test_loads();
        for (int i = 0; i < 6; i++) begin
            case (i)
                0: drive(0, 0, 1, 1, 2'b01, 3'b000, 5'd3, 32'h00001001, 32'h80F07F11, 32'h0);
                1: drive(0, 0, 1, 1, 2'b01, 3'b000, 5'd3, 32'h00001003, 32'h80F07F11, 32'h0);
                2: drive(0, 0, 1, 1, 2'b01, 3'b101, 5'd4, 32'h00001002, 32'h80F07F11, 32'h0);
                3: drive(0, 0, 1, 1, 2'b01, 3'b001, 5'd4, 32'h00001002, 32'h80F07F11, 32'h0);
                4: drive(0, 0, 1, 1, 2'b01, 3'b100, 5'd6, 32'h00001003, 32'h80F07F11, 32'h0);
                default: drive(0, 0, 1, 1, 2'b01, 3'b010, 5'd7, 32'h00001000, 32'h80F07F11, 32'h0);
            endcase
            exp = sb.pop_front(); got = observe(); n_checks++;
            if (got !== exp) $display("FAIL load[%0d] got=%h exp=%h", i, got, exp);
            else n_pass++;
        end
    endtask

    task automatic test_hazards();
        for (int i = 0; i < 8; i++) begin
            case (i)
                0: drive(0, 0, 1, 1, 2'b00, 3'b000, 5'd7, 32'h00000077, 32'h0, 32'h0);
                1, 2, 3: drive(1, 0, 1, 1, 2'b00, 3'b000, 5'd8, 32'h00000088 + i, 32'h0, 32'h0);
                4: drive(1, 1, 1, 1, 2'b00, 3'b000, 5'd9, 32'h00000099, 32'h0, 32'h0);
                5: drive(0, 0, 1, 1, 2'b00, 3'b000, 5'd10, 32'h000000AA, 32'h0, 32'h0);
                6: drive(0, 1, 1, 1, 2'b00, 3'b000, 5'd11, 32'h000000BB, 32'h0, 32'h0);
                default: drive(0, 0, 0, 1, 2'b00, 3'b000, 5'd12, 32'h000000CC, 32'h0, 32'h0);
            endcase
            exp = sb.pop_front(); got = observe(); n_checks++;
            if (got !== exp) $display("FAIL hazard[%0d] got=%h exp=%h", i, got, exp);
            else n_pass++;
        end
    endtask

    task automatic test_misaligned();
        for (int i = 0; i < 4; i++) begin
            case (i)
                0: drive(0, 0, 0, 1, 2'b01, 3'b010, 5'd2, 32'h00002002, 32'hCAFEF00D, 32'h0);
                1: drive(0, 0, 1, 1, 2'b01, 3'b010, 5'd2, 32'h00002002, 32'hCAFEF00D, 32'h0);
                2: drive(0, 0, 1, 1, 2'b01, 3'b010, 5'd2, 32'h00002004, 32'h01234567, 32'h0);
                default: drive(0, 0, 1, 1, 2'b01, 3'b001, 5'd2, 32'h00002001, 32'h01234567, 32'h0);
            endcase
            exp = sb.pop_front(); got = observe(); n_checks++;
            if (got !== exp) $display("FAIL misaligned[%0d] got=%h exp=%h", i, got, exp);
            else n_pass++;
        end
    endtask

    task automatic test_back_to_back();
        logic [2:0] f3s [6];
        f3s = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101, 3'b011};
        for (int i = 0; i < 40; i++) begin
            drive(($urandom_range(0, 3) == 0), ($urandom_range(0, 7) == 0),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  2'($urandom_range(0, 3)), f3s[$urandom_range(0, 5)],
                  5'($urandom_range(0, 31)), $urandom, $urandom, $urandom);
            exp = sb.pop_front(); got = observe(); n_checks++;
            if (got !== exp) $display("FAIL back_to_back[%0d] got=%h exp=%h", i, got, exp);
            else n_pass++;
        end
    endtask

    task automatic test_wrap();
        int guard = 0;
        while (mdl.cnt[3:0] != 4'hF && guard < 20) begin
            guard++;
            drive(0, 0, 1, 1, 2'b00, 3'b000, 5'd13, 32'h0000000D, 32'h0, 32'h0);
            exp = sb.pop_front(); got = observe(); n_checks++;
            if (got !== exp) $display("FAIL wrap_fill got=%h exp=%h", got, exp);
            else n_pass++;
        end
        drive(0, 0, 1, 1, 2'b00, 3'b000, 5'd14, 32'h0000000E, 32'h0, 32'h0);
        exp = sb.pop_front(); got = observe(); n_checks++;
        if (got.cnt4 !== 4'h0 || got !== exp)
            $display("FAIL wrap got_cnt4=%0d exp_cnt4=0 got=%h exp=%h", got.cnt4, got, exp);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_alu_write();
        test_x0_jal();
        test_reset_mid();
        test_loads();
        test_hazards();
        test_misaligned();
        test_back_to_back();
        test_wrap();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/writeback_stage.md
Name: writeback_stage

Overview:
- MEM/WB pipeline register plus writeback-result formation for the RV32I pipeline.
- Captures memory-stage results, sign/zero-extends load data, and selects the result by ResultSrc.
- Drives the WB value, destination register and write enable back into the decode stage register file.
- Counts retired instructions for bring-up and performance checks.

Parameters:
- XLEN, 32, datapath width
- CNT_W, 32, width of retired-instruction counter

Ports:
- clk  input  1  pipeline clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- stall  input  1  hold MEM/WB register contents
- flush  input  1  insert bubble into MEM/WB register
- m_valid  input  1  memory-stage slot holds a real instruction
- m_RegWrite  input  1  instruction writes rd
- m_ResultSrc  input  2  00 ALU result, 01 load data, 10 PC+4, 11 reserved
- m_Funct3  input  3  load width/sign (000 lb, 001 lh, 010 lw, 100 lbu, 101 lhu)
- m_Rd  input  5  destination register
- m_ALUResult  input  XLEN  ALU result / load address
- m_ReadData  input  XLEN  raw 32-bit word from data memory
- m_PCPlus4  input  XLEN  PC+4 of instruction
- WB  output  XLEN  writeback data to register file
- Rd_W  output  5  writeback destination
- RegWrite_W  output  1  register-file write enable
- valid_W  output  1  writeback slot holds a real instruction
- retire_count  output  CNT_W  retired-instruction count
- load_misaligned  output  1  sticky flag, misaligned load retired

Behaviour:
- Reset (rst_n=0, asynchronous):
  - All registered state and outputs go to 0: WB, Rd_W, RegWrite_W, valid_W, retire_count, load_misaligned.
  - Deassertion is sampled on clk.
- Latency: one cycle. Inputs sampled at edge N appear on the W-outputs after edge N.
- Register update priority per edge: flush > stall > load.
  - flush: valid_W=0, RegWrite_W=0. Rd_W and WB hold their previous values.
  - stall (no flush): all W registers hold.
  - Otherwise: capture the m_* fields.
  - flush and stall together: flush wins.
- RegWrite_W = m_valid & m_RegWrite & (m_Rd != 0), evaluated at capture. x0 is never written.
- Result select is performed before the register, so WB is a registered value:
  - ResultSrc 00: m_ALUResult.
  - ResultSrc 01: extended load data.
  - ResultSrc 10: m_PCPlus4.
  - ResultSrc 11: WB = 0 and RegWrite_W forced 0.
- Load extraction uses byte offset = m_ALUResult[1:0]:
  - lb/lbu: byte at offset, sign- or zero-extended.
  - lh/lhu: halfword at offset[1]*16, sign- or zero-extended.
  - lw: full word.
  - Undefined funct3 with ResultSrc 01: treated as lw.
- Misaligned load: lh/lhu with offset[0]=1, or lw with offset!=0.
  - Data is still produced using the aligned lane; no exception is raised.
  - load_misaligned is set on capture when m_valid=1 and is sticky until reset.
- retire_count increments by 1 on every edge where valid_W becomes 1 via a normal capture, i.e. no stall, no flush, m_valid=1.
  - Wraps from all-ones to 0 silently.
  - A stalled valid instruction is counted once only.
- Bubbles (m_valid=0) are captured with valid_W=0, RegWrite_W=0. WB still takes the selected value, which is don't-care for verification.
- Reset asserted mid-stall or mid-flush: state clears immediately; no pending update survives.

Decomposition:
- Shared package rv_pkg:
  - ResultSrc encodings (RES_ALU, RES_MEM, RES_PC4).
  - Load funct3 constants (F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU).
  - XLEN.
- Sub-module load_extend: combinational. Inputs are the raw word, funct3 and offset; outputs are the extended data and a misaligned flag. It is reused later by the forwarding path.

Test Plan:
- Reset: rst_n=0 mid-run with retire_count=5 → all outputs 0 immediately, before any clock edge.
- ALU write: m_valid=1, RegWrite=1, ResultSrc=00, Rd=5, ALUResult=0x0000000A → next cycle WB=0x0A, Rd_W=5, RegWrite_W=1, retire_count+1.
- Loads: ReadData=0x80F07F11, ALUResult low bits=01, lb → WB=0x0000007F. Offset 3, lb → WB=0xFFFFFF80. Offset 2, lhu → WB=0x000080F0. Offset 2, lh → WB=0xFFFF80F0.
- x0 and jal: Rd=0 with RegWrite=1 → RegWrite_W=0 and the instruction still counts. ResultSrc=10 with PCPlus4=0x104 → WB=0x104.
- Hazards: stall held 3 cycles → W outputs frozen and the count increments once. flush+stall together → valid_W=0, RegWrite_W=0, no count.
- Misaligned and wrap: lw at offset 2 → load_misaligned=1 and stays 1 after later aligned loads. Force retire_count=0xFFFFFFFF, retire one instruction → 0.
